vga_timgen_pro: RTL and testbench

Parametrised next-generation VGA/LCD timing generator. Runs the horizontal and vertical sync/back-porch/active/front-porch sequences and adds programmable sync polarity, a Y position output and a frame counter. Timing fields are held in shadow registers so the programmed timing changes only at frame boundaries. Sits between the VGA control registers and the pixel FIFO/output stage; de_o, pos_x_o and pos_y_o drive pixel fetch.

---
 rtl/vga_timgen_pro.sv | 179 +++++++++++++++++
 tb/tb_vga_timgen_pro.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timgen_pro.sv
// vga_timgen_pro -- VGA/LCD timing generator.
// Horizontal and vertical SYNC/BP/ACT/FP sequencers driven from shadowed
// timing fields, with programmable sync polarity, pixel/line position outputs
// and a completed-frame counter.
// Optional line-compare interrupt output: define VGA_TIMGEN_LINECMP_EN.
module vga_timgen_pro #(
   parameter int TB_WIDTH  = 8,
   parameter int VB_WIDTH  = 12,
   parameter int CNT_WIDTH = 12,
   parameter int FRM_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 en_i,
   input  logic                 pclk_en_i,
   input  logic [TB_WIDTH-1:0]  hsnsize_i,
   input  logic [TB_WIDTH-1:0]  hbpsize_i,
   input  logic [TB_WIDTH-1:0]  hfpsize_i,
   input  logic [VB_WIDTH-1:0]  hvlen_i,
   input  logic [TB_WIDTH-1:0]  vsnsize_i,
   input  logic [TB_WIDTH-1:0]  vbpsize_i,
   input  logic [TB_WIDTH-1:0]  vfpsize_i,
   input  logic [VB_WIDTH-1:0]  vvlen_i,
   input  logic                 hpol_i,
   input  logic                 vpol_i,
   output logic [CNT_WIDTH-1:0] pos_x_o,
   output logic [CNT_WIDTH-1:0] pos_y_o,
   output logic                 hsync_o,
   output logic                 vsync_o,
   output logic                 hend_o,
   output logic                 vend_o,
   output logic                 de_o,
   output logic [FRM_WIDTH-1:0] frame_cnt_o
`ifdef VGA_TIMGEN_LINECMP_EN
   ,
   input  logic [VB_WIDTH-1:0]  lcmp_i,
   output logic                 lcmp_o
`endif
);

   // Region counters must hold the widest field of either kind.
   localparam int RW = (VB_WIDTH > TB_WIDTH) ? VB_WIDTH : TB_WIDTH;

   typedef enum logic [1:0] {ST_SYNC, ST_BP, ST_ACT, ST_FP} state_t;

   typedef struct packed {
      logic [TB_WIDTH-1:0] sn;
      logic [TB_WIDTH-1:0] bp;
      logic [TB_WIDTH-1:0] fp;
      logic [VB_WIDTH-1:0] vlen;
   } axis_cfg_t;

   axis_cfg_t     h_cfg, v_cfg;
   state_t        hstate, vstate;
   logic [RW-1:0] hcnt, vcnt;
   logic          en_q;
   logic          tick, h_last, v_last, hend, vend;

   // Position outputs would silently lose active-line bits otherwise.
   if (CNT_WIDTH < VB_WIDTH) begin : g_width_check
      $error("vga_timgen_pro: CNT_WIDTH must be >= VB_WIDTH");
   end

   // Zero-based length of the region a sequencer is currently in.
   function automatic logic [RW-1:0] region_len(input state_t st, input axis_cfg_t cfg);
      logic [RW-1:0] len;
      len = '0;
      unique case (st)
         ST_SYNC: len = RW'(cfg.sn);
         ST_BP:   len = RW'(cfg.bp);
         ST_ACT:  len = RW'(cfg.vlen);
         ST_FP:   len = RW'(cfg.fp);
      endcase
      return len;
   endfunction

   function automatic state_t next_state(input state_t st);
      state_t nxt;
      nxt = ST_SYNC;
      unique case (st)
         ST_SYNC: nxt = ST_BP;
         ST_BP:   nxt = ST_ACT;
         ST_ACT:  nxt = ST_FP;
         ST_FP:   nxt = ST_SYNC;
      endcase
      return nxt;
   endfunction

   assign tick   = en_i && pclk_en_i;
   assign h_last = (hcnt == region_len(hstate, h_cfg));
   assign v_last = (vcnt == region_len(vstate, v_cfg));
   assign hend   = tick && (hstate == ST_FP) && h_last;
   assign vend   = hend && (vstate == ST_FP) && v_last;

   // Shadow timing: track the inputs while idle, otherwise reload only at frame end.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n_i) begin
         h_cfg <= '0;
         v_cfg <= '0;
      end else if (!en_i || vend) begin
         h_cfg <= '{sn: hsnsize_i, bp: hbpsize_i, fp: hfpsize_i, vlen: hvlen_i};
         v_cfg <= '{sn: vsnsize_i, bp: vbpsize_i, fp: vfpsize_i, vlen: vvlen_i};
      end
   end

   // Horizontal sequencer: one step per pixel tick.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hstate <= ST_SYNC;
         hcnt   <= '0;
      end else if (!en_i) begin
         hstate <= ST_SYNC;
         hcnt   <= '0;
      end else if (tick) begin
         if (h_last) begin
            hstate <= next_state(hstate);
            hcnt   <= '0;
         end else begin
            hcnt <= hcnt + RW'(1);
         end
      end
   end

   // Vertical sequencer: one step per completed line.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vstate <= ST_SYNC;
         vcnt   <= '0;
      end else if (!en_i) begin
         vstate <= ST_SYNC;
         vcnt   <= '0;
      end else if (hend) begin
         if (v_last) begin
            vstate <= next_state(vstate);
            vcnt   <= '0;
         end else begin
            vcnt <= vcnt + RW'(1);
         end
      end
   end

   // Enable history for output gating, and the completed-frame counter.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         en_q        <= 1'b0;
         frame_cnt_o <= '0;
      end else begin
         en_q <= en_i;
         if (vend) frame_cnt_o <= frame_cnt_o + FRM_WIDTH'(1);
      end
   end

   assign hend_o  = hend;
   assign vend_o  = vend;
   assign de_o    = (hstate == ST_ACT) && (vstate == ST_ACT) && en_q;
   assign pos_x_o = (hstate == ST_ACT) ? CNT_WIDTH'(hcnt) : '0;
   assign pos_y_o = (vstate == ST_ACT) ? CNT_WIDTH'(vcnt) : '0;
   assign hsync_o = en_q ? ((hstate == ST_SYNC) ^ hpol_i) : hpol_i;
   assign vsync_o = en_q ? ((vstate == ST_SYNC) ^ vpol_i) : vpol_i;

`ifdef VGA_TIMGEN_LINECMP_EN
   logic lcmp_hit;

   // The next line step lands on active line lcmp_i (line 0 entered from BP).
   assign lcmp_hit = ((vstate == ST_BP) && v_last && (lcmp_i == '0)) ||
                     ((vstate == ST_ACT) && !v_last && ((vcnt + RW'(1)) == RW'(lcmp_i)));

   // Line-compare pulse, one clock wide after the matching line step.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         lcmp_o <= 1'b0;
      end else begin
         lcmp_o <= hend && lcmp_hit;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timgen_pro.sv
// Directed bench for vga_timgen_pro; line-compare checks enabled with VGA_TIMGEN_LINECMP_EN.
module tb_vga_timgen_pro;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        en_i = 1'b0;
   logic        pclk_en_i = 1'b0;
   logic [7:0]  hsnsize_i = '0, hbpsize_i = '0, hfpsize_i = '0;
   logic [11:0] hvlen_i = '0;
   logic [7:0]  vsnsize_i = '0, vbpsize_i = '0, vfpsize_i = '0;
   logic [11:0] vvlen_i = '0;
   logic        hpol_i = 1'b0, vpol_i = 1'b0;
   logic [11:0] pos_x_o, pos_y_o;
   logic        hsync_o, vsync_o, hend_o, vend_o, de_o;
   logic [15:0] frame_cnt_o;
`ifdef VGA_TIMGEN_LINECMP_EN
   logic [11:0] lcmp_i = 12'd1;
   logic        lcmp_o;
   int          lcmp_pulses = 0;
`endif

   int n_pass = 0;
   int n_total = 0;
   int frm_base = 0;

   vga_timgen_pro dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .pclk_en_i(pclk_en_i),
      .hsnsize_i(hsnsize_i), .hbpsize_i(hbpsize_i), .hfpsize_i(hfpsize_i), .hvlen_i(hvlen_i),
      .vsnsize_i(vsnsize_i), .vbpsize_i(vbpsize_i), .vfpsize_i(vfpsize_i), .vvlen_i(vvlen_i),
      .hpol_i(hpol_i), .vpol_i(vpol_i),
      .pos_x_o(pos_x_o), .pos_y_o(pos_y_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
      .hend_o(hend_o), .vend_o(vend_o), .de_o(de_o), .frame_cnt_o(frame_cnt_o)
`ifdef VGA_TIMGEN_LINECMP_EN
      , .lcmp_i(lcmp_i), .lcmp_o(lcmp_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // {hsync, vsync, hend, vend, de, pos_x, pos_y, frame_cnt}
   function automatic logic [44:0] outs();
      return {hsync_o, vsync_o, hend_o, vend_o, de_o, pos_x_o, pos_y_o, frame_cnt_o};
   endfunction

   // Programs a timing set, enables from idle and compares every clock against
   // an arithmetic frame model. hvlen_i switches from ha0 to ha1 at cycle chg.
   task automatic run_stream(input string name, input int hs, input int hb, input int ha0,
                             input int ha1, input int hf, input int vs, input int vb,
                             input int va, input int vf, input int div, input int ncyc,
                             input int chg, input logic hp, input logic vp);
      int hl0, hl1, vl, fl0, fl1, t, tt, fd, x, ln, ha, hl;
      logic hact, vact, tk, e_hend, e_vend, e_hs, e_vs, e_de;
      logic [11:0] e_px, e_py;
      logic [44:0] exp_v, got_v;
      @(negedge clk_i);
      en_i = 1'b0; pclk_en_i = 1'b1;
      hsnsize_i = 8'(hs); hbpsize_i = 8'(hb); hvlen_i = 12'(ha0); hfpsize_i = 8'(hf);
      vsnsize_i = 8'(vs); vbpsize_i = 8'(vb); vvlen_i = 12'(va); vfpsize_i = 8'(vf);
      hpol_i = hp; vpol_i = vp;
      vl  = vs + vb + va + vf + 4;
      hl0 = hs + hb + ha0 + hf + 4;
      hl1 = hs + hb + ha1 + hf + 4;
      fl0 = hl0 * vl;
      fl1 = hl1 * vl;
`ifdef VGA_TIMGEN_LINECMP_EN
      lcmp_pulses = 0;
`endif
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk_i);
         if (c == 0) en_i = 1'b1;
         if (c == chg) hvlen_i = 12'(ha1);
         pclk_en_i = (c % div == 0);
         #1;
         t = (c + div - 1) / div;
         if (t < fl0) begin
            fd = 0; tt = t; ha = ha0; hl = hl0;
         end else begin
            fd = 1 + (t - fl0) / fl1; tt = (t - fl0) % fl1; ha = ha1; hl = hl1;
         end
         x  = tt % hl;
         ln = tt / hl;
         hact   = (x >= hs + hb + 2) && (x <= hs + hb + ha + 2);
         vact   = (ln >= vs + vb + 2) && (ln <= vs + vb + va + 2);
         tk     = (c % div == 0);
         e_hend = tk && (x == hl - 1);
         e_vend = e_hend && (ln == vl - 1);
         e_hs   = (c == 0) ? hp : ((x <= hs) ^ hp);
         e_vs   = (c == 0) ? vp : ((ln <= vs) ^ vp);
         e_de   = (c > 0) && hact && vact;
         e_px   = hact ? 12'(x - (hs + hb + 2)) : 12'd0;
         e_py   = vact ? 12'(ln - (vs + vb + 2)) : 12'd0;
         exp_v  = {e_hs, e_vs, e_hend, e_vend, e_de, e_px, e_py, 16'(frm_base + fd)};
         got_v  = outs();
         n_total++;
         if (got_v !== exp_v)
            $display("FAIL %s c=%0d got=%h exp=%h", name, c, got_v, exp_v);
         else
            n_pass++;
`ifdef VGA_TIMGEN_LINECMP_EN
         begin
            logic e_lc;
            e_lc = (c >= 1) && ((c - 1) % div == 0) && (x == 0) &&
                   (int'(lcmp_i) <= va) && (ln == vs + vb + 2 + int'(lcmp_i));
            if (lcmp_o === 1'b1) lcmp_pulses++;
            n_total++;
            if (lcmp_o !== e_lc)
               $display("FAIL %s_lcmp c=%0d got=%b exp=%b", name, c, lcmp_o, e_lc);
            else
               n_pass++;
         end
`endif
      end
      // The clock edge after the last sampled cycle still ticks.
      t = (ncyc + div - 1) / div;
      fd = (t < fl0) ? 0 : 1 + (t - fl0) / fl1;
      frm_base += fd;
   endtask

   task automatic test_reset();
      #12;
      n_total++;
      if (outs() !== 45'd0) $display("FAIL reset_pol0 got=%h exp=%h", outs(), 45'd0);
      else n_pass++;
      hpol_i = 1'b1; vpol_i = 1'b1;
      #1;
      n_total++;
      if (outs() !== {2'b11, 43'd0}) $display("FAIL reset_pol1 got=%h exp=%h", outs(), {2'b11, 43'd0});
      else n_pass++;
      @(negedge clk_i);
      rst_n_i = 1'b1;
      frm_base = 0;
   endtask

   task automatic test_basic();
      // 9-clk lines, 5-line frames: 45 clks per frame.
      run_stream("basic", 1, 1, 3, 3, 0, 0, 0, 1, 0, 1, 100, -1, 1'b0, 1'b0);
   endtask

   task automatic test_polarity();
      run_stream("polarity", 1, 1, 3, 3, 0, 0, 0, 1, 0, 1, 100, -1, 1'b1, 1'b1);
   endtask

   task automatic test_pclk_div();
      run_stream("pclk_div2", 1, 1, 3, 3, 0, 0, 0, 1, 0, 2, 200, -1, 1'b0, 1'b0);
   endtask

   task automatic test_midframe_change();
      // First frame keeps 9-clk lines, later frames use 13-clk lines.
      run_stream("midframe", 1, 1, 3, 7, 0, 0, 0, 1, 0, 1, 180, 20, 1'b0, 1'b0);
   endtask

   task automatic test_en_drop();
      logic [44:0] exp_v;
      run_stream("drop_pre", 1, 1, 3, 3, 0, 0, 0, 1, 0, 1, 30, -1, 1'b1, 1'b1);
      @(negedge clk_i);
      en_i = 1'b0;
      #1;
      n_total++;
      if ({hend_o, vend_o, frame_cnt_o} !== {2'b00, 16'(frm_base)})
         $display("FAIL drop_first got=%h exp=%h", {hend_o, vend_o, frame_cnt_o}, {2'b00, 16'(frm_base)});
      else n_pass++;
      exp_v = {2'b11, 27'd0, 16'(frm_base)};
      for (int k = 1; k < 5; k++) begin
         @(negedge clk_i);
         #1;
         n_total++;
         if (outs() !== exp_v) $display("FAIL drop_idle k=%0d got=%h exp=%h", k, outs(), exp_v);
         else n_pass++;
      end
      run_stream("drop_post", 1, 1, 3, 3, 0, 0, 0, 1, 0, 1, 60, -1, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [44:0] exp_v;
      run_stream("rst_pre", 1, 1, 3, 3, 0, 0, 0, 1, 0, 1, 68, -1, 1'b1, 1'b1);
      @(negedge clk_i);
      #2 rst_n_i = 1'b0;
      #1;
      exp_v = {2'b11, 43'd0};
      n_total++;
      if (outs() !== exp_v) $display("FAIL reset_mid got=%h exp=%h", outs(), exp_v);
      else n_pass++;
`ifdef VGA_TIMGEN_LINECMP_EN
      n_total++;
      if (lcmp_o !== 1'b0) $display("FAIL reset_mid_lcmp got=%b exp=0", lcmp_o);
      else n_pass++;
`endif
      @(negedge clk_i);
      rst_n_i = 1'b1;
      frm_base = 0;
   endtask

`ifdef VGA_TIMGEN_LINECMP_EN
   task automatic test_linecmp();
      lcmp_i = 12'd1;
      run_stream("lcmp1", 1, 1, 3, 3, 0, 0, 0, 1, 0, 1, 100, -1, 1'b0, 1'b0);
      n_total++;
      if (lcmp_pulses !== 2) $display("FAIL lcmp1_count got=%0d exp=2", lcmp_pulses);
      else n_pass++;
      lcmp_i = 12'd5;
      run_stream("lcmp5", 1, 1, 3, 3, 0, 0, 0, 1, 0, 1, 100, -1, 1'b0, 1'b0);
      n_total++;
      if (lcmp_pulses !== 0) $display("FAIL lcmp5_count got=%0d exp=0", lcmp_pulses);
      else n_pass++;
      lcmp_i = 12'd1;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_polarity();
      test_pclk_div();
      test_midframe_change();
      test_en_drop();
      test_reset_mid();
`ifdef VGA_TIMGEN_LINECMP_EN
      test_linecmp();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
